encoder_txrx_sm: RTL and testbench

Gigabit-style PCS transmit/receive control block sitting between the GMII-side MAC interface and the PAM5 symbol line interface. The TX path frames octets with start/end delimiters, scrambles them with a side-stream LFSR and maps each octet onto four signed 3-bit PAM5 lane symbols. The RX path tracks received delimiters and drives rx_dv/rx_er/rxd from a pre-decoded octet. It also flags collisions and holds a sticky error status.

---
 rtl/encoder_txrx_pkg.sv | 65 ++++++
 rtl/pcs_scrambler.sv | 29 ++
 rtl/encoder_txrx_sm.sv | 245 ++++++++++++++++++++++++
 tb/tb_encoder_txrx_sm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_txrx_pkg.sv
// encoder_txrx_pkg: shared types and constants for the PAM5 PCS control block.
// Holds the TX/RX state encodings, PAM5 symbol codes, delimiter vectors,
// scrambler seed/taps and the octet-to-symbol mapping helpers.
// Symbol vectors are packed as {lane3, lane2, lane1, lane0}, 3 bits per lane.
package encoder_txrx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SSD1 = 3'd1,
        SSD2 = 3'd2,
        DATA = 3'd3,
        ESD1 = 3'd4,
        ESD2 = 3'd5
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_SSD2 = 2'd1,
        R_DATA = 2'd2
    } rx_state_t;

    // PAM5 levels as 3-bit two's complement codes
    localparam logic [2:0] PAM_M2 = 3'b110;
    localparam logic [2:0] PAM_M1 = 3'b111;
    localparam logic [2:0] PAM_0  = 3'b000;
    localparam logic [2:0] PAM_P1 = 3'b001;
    localparam logic [2:0] PAM_P2 = 3'b010;

    // Delimiter and error vectors, {lane3, lane2, lane1, lane0}
    localparam logic [11:0] VEC_SSD1  = {PAM_P2, PAM_P2, PAM_P2, PAM_P2};
    localparam logic [11:0] VEC_SSD2  = {PAM_M2, PAM_M2, PAM_P2, PAM_P2};
    localparam logic [11:0] VEC_ESD1  = {PAM_M2, PAM_P2, PAM_M2, PAM_P2};
    localparam logic [11:0] VEC_ESD2  = {PAM_P2, PAM_M2, PAM_P2, PAM_M2};
    localparam logic [11:0] VEC_TXERR = {PAM_P2, PAM_M2, PAM_M2, PAM_M2};

    // Side-stream scrambler: 33-bit shift register, feedback from bits 32 and 12
    localparam int          SCR_W      = 33;
    localparam int          SCR_TAP_HI = 32;
    localparam int          SCR_TAP_LO = 12;
    localparam logic [32:0] SCR_SEED   = 33'h1;

    // Two scrambled bits onto one PAM5 level
    function automatic logic [2:0] pam5_of_pair(input logic [1:0] d);
        logic [2:0] s;
        case (d)
            2'b00:   s = PAM_0;
            2'b01:   s = PAM_P1;
            2'b11:   s = PAM_P2;
            default: s = PAM_M1;
        endcase
        return s;
    endfunction

    // Scrambled octet onto four lanes; lane k takes bits [2k+1:2k]
    function automatic logic [11:0] pam5_of_octet(input logic [7:0] sd);
        return {pam5_of_pair(sd[7:6]), pam5_of_pair(sd[5:4]),
                pam5_of_pair(sd[3:2]), pam5_of_pair(sd[1:0])};
    endfunction

    // Two's complement negation of a PAM5 code
    function automatic logic [2:0] pam5_neg(input logic [2:0] s);
        return (~s) + 3'd1;
    endfunction

endpackage

// File: rtl/pcs_scrambler.sv
// pcs_scrambler: side-stream LFSR for the TX path.
// Shifts left one bit per advance, inserting scr[32]^scr[12] at bit 0.
// Returns to the seed on either the async reset or the sync PCS reset.
module pcs_scrambler
    import encoder_txrx_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sync_rst,
    input  logic             i_advance,
    output logic [SCR_W-1:0] o_scr
);

    logic [SCR_W-1:0] r_scr;

    // LFSR state: seed on reset, one shift per advance strobe
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scr <= SCR_SEED;
        end else if (i_sync_rst) begin
            r_scr <= SCR_SEED;
        end else if (i_advance) begin
            r_scr <= {r_scr[SCR_W-2:0], r_scr[SCR_TAP_HI] ^ r_scr[SCR_TAP_LO]};
        end
    end

    assign o_scr = r_scr;

endmodule

// File: rtl/encoder_txrx_sm.sv
// encoder_txrx_sm: PCS transmit/receive control between GMII and PAM5 lanes.
// TX frames octets with SSD/ESD delimiters, scrambles and maps them onto four
// PAM5 lanes. The RX tracker, collision flag and sticky RX error status are
// built only when ENCODER_TXRX_SM_RX_EN is defined; otherwise those outputs
// are tied off and the RX inputs are ignored.
// Handshake: the TX symbol register is loaded on strobe = symb_timer_done &
// tx_symb_vector_ready, and tx_symb_vector_valid is high for exactly the
// cycle after each strobe. RX vectors are consumed on any cycle where
// rx_symb_vector_valid is high; rx_symb_vector_ready is always 1.
module encoder_txrx_sm
    import encoder_txrx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_tx_enable,
    input  logic              io_tx_mode,
    input  logic              io_tx_error,
    input  logic [7:0]        io_txd,
    input  logic              io_symb_timer_done,
    input  logic [31:0]       io_n,
    input  logic [31:0]       io_n0,
    input  logic              io_loc_rcvr_status,
    input  logic              io_rx_symb_vector_valid,
    input  logic signed [2:0] io_rx_symb_vector_bits_0,
    input  logic signed [2:0] io_rx_symb_vector_bits_1,
    input  logic signed [2:0] io_rx_symb_vector_bits_2,
    input  logic signed [2:0] io_rx_symb_vector_bits_3,
    input  logic [7:0]        io_decoded_rx_symb_vector,
    input  logic              io_pcs_reset,
    input  logic              io_tx_symb_vector_ready,
    output logic              io_tx_symb_vector_valid,
    output logic signed [2:0] io_tx_symb_vector_bits_0,
    output logic signed [2:0] io_tx_symb_vector_bits_1,
    output logic signed [2:0] io_tx_symb_vector_bits_2,
    output logic signed [2:0] io_tx_symb_vector_bits_3,
    output logic [7:0]        io_rxd,
    output logic              io_rx_dv,
    output logic              io_rx_er,
    output logic              io_rxerror_status,
    output logic              io_col,
    output logic              io_rx_symb_vector_ready
);

    logic             w_strobe;
    logic [SCR_W-1:0] w_scr;
    logic             w_n_odd;
    logic [11:0]      w_idle_vec;
    logic [11:0]      w_sym_next;
    logic             w_tx_active_nx;
    logic             w_unused;
    tx_state_t        r_tx_state;
    tx_state_t        w_tx_next;
    logic [11:0]      r_sym;
    logic             r_valid;

    assign w_strobe = io_symb_timer_done & io_tx_symb_vector_ready;

    // Only the parity of (n - n0) matters, and that is the XOR of the LSBs
    assign w_n_odd = io_n[0] ^ io_n0[0];

    pcs_scrambler u_scrambler (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_sync_rst (io_pcs_reset),
        .i_advance  (w_strobe),
        .o_scr      (w_scr)
    );

    // Idle pattern: +/-2 per lane from scrambler bits, lane 3 flipped on odd index
    always_comb begin
        w_idle_vec[2:0]  = w_scr[0] ? PAM_P2 : PAM_M2;
        w_idle_vec[5:3]  = w_scr[1] ? PAM_P2 : PAM_M2;
        w_idle_vec[8:6]  = w_scr[2] ? PAM_P2 : PAM_M2;
        w_idle_vec[11:9] = w_scr[3] ? PAM_P2 : PAM_M2;
        if (w_n_odd) begin
            w_idle_vec[11:9] = pam5_neg(w_scr[3] ? PAM_P2 : PAM_M2);
        end
    end

    // TX next state; only committed on a strobe
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            IDLE:    if (io_tx_enable && io_loc_rcvr_status) w_tx_next = SSD1;
            SSD1:    w_tx_next = SSD2;
            SSD2:    w_tx_next = DATA;
            DATA:    if (!io_tx_enable) w_tx_next = ESD1;
            ESD1:    w_tx_next = ESD2;
            ESD2:    w_tx_next = IDLE;
            default: w_tx_next = IDLE;
        endcase
    end

    // Symbols for the state being entered, using the current scrambler and txd
    always_comb begin
        w_sym_next = '0;
        case (w_tx_next)
            IDLE:    w_sym_next = w_idle_vec;
            SSD1:    w_sym_next = VEC_SSD1;
            SSD2:    w_sym_next = VEC_SSD2;
            DATA:    w_sym_next = io_tx_error ? VEC_TXERR
                                              : pam5_of_octet(io_txd ^ w_scr[7:0]);
            ESD1:    w_sym_next = VEC_ESD1;
            ESD2:    w_sym_next = VEC_ESD2;
            default: w_sym_next = '0;
        endcase
        // SEND_Z: FSM keeps running, line sees zeros
        if (!io_tx_mode) begin
            w_sym_next = '0;
        end
    end

    // TX state, symbol register and valid pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_sym      <= '0;
            r_valid    <= 1'b0;
        end else if (io_pcs_reset) begin
            r_tx_state <= IDLE;
            r_sym      <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_strobe;
            if (w_strobe) begin
                r_tx_state <= w_tx_next;
                r_sym      <= w_sym_next;
            end
        end
    end

    assign w_tx_active_nx = ((w_strobe ? w_tx_next : r_tx_state) != IDLE);

    assign io_tx_symb_vector_valid  = r_valid;
    assign io_tx_symb_vector_bits_0 = r_sym[2:0];
    assign io_tx_symb_vector_bits_1 = r_sym[5:3];
    assign io_tx_symb_vector_bits_2 = r_sym[8:6];
    assign io_tx_symb_vector_bits_3 = r_sym[11:9];
    assign io_rx_symb_vector_ready  = 1'b1;

`ifdef ENCODER_TXRX_SM_RX_EN
    logic [11:0] w_rx_vec;
    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic        w_rx_er_set;
    logic        w_rx_dv_load;
    logic        w_rx_dv_clear;
    logic        w_col_nx;
    logic [7:0]  r_rxd;
    logic        r_rx_dv;
    logic        r_rx_er;
    logic        r_rxerr;
    logic        r_col;

    assign w_rx_vec = {io_rx_symb_vector_bits_3, io_rx_symb_vector_bits_2,
                       io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_0};

    // RX delimiter tracking; moves only on a valid symbol vector
    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_er_set   = 1'b0;
        w_rx_dv_load  = 1'b0;
        w_rx_dv_clear = 1'b0;
        if (io_rx_symb_vector_valid) begin
            case (r_rx_state)
                R_IDLE: begin
                    if (w_rx_vec == VEC_SSD1) w_rx_next = R_SSD2;
                end
                R_SSD2: begin
                    if (w_rx_vec == VEC_SSD2) begin
                        w_rx_next = R_DATA;
                    end else begin
                        w_rx_next   = R_IDLE;
                        w_rx_er_set = 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_rx_vec == VEC_ESD1) begin
                        w_rx_next     = R_IDLE;
                        w_rx_dv_clear = 1'b1;
                    end else begin
                        w_rx_dv_load = 1'b1;
                    end
                end
                default: w_rx_next = R_IDLE;
            endcase
        end
    end

    // Collision reflects the states both FSMs hold after this edge
    assign w_col_nx = w_tx_active_nx && (w_rx_next != R_IDLE);

    // RX state, data outputs, error pulse, sticky status and collision flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state <= R_IDLE;
            r_rxd      <= '0;
            r_rx_dv    <= 1'b0;
            r_rx_er    <= 1'b0;
            r_rxerr    <= 1'b0;
            r_col      <= 1'b0;
        end else if (io_pcs_reset) begin
            r_rx_state <= R_IDLE;
            r_rxd      <= '0;
            r_rx_dv    <= 1'b0;
            r_rx_er    <= 1'b0;
            r_rxerr    <= 1'b0;
            r_col      <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_er    <= w_rx_er_set;
            r_rxerr    <= r_rxerr | w_rx_er_set;
            r_col      <= w_col_nx;
            if (w_rx_dv_load) begin
                r_rx_dv <= 1'b1;
                r_rxd   <= io_decoded_rx_symb_vector;
            end else if (w_rx_dv_clear) begin
                r_rx_dv <= 1'b0;
                r_rxd   <= '0;
            end
        end
    end

    assign io_rxd            = r_rxd;
    assign io_rx_dv          = r_rx_dv;
    assign io_rx_er          = r_rx_er;
    assign io_rxerror_status = r_rxerr;
    assign io_col            = r_col;

    assign w_unused = ^{io_n[31:1], io_n0[31:1], w_scr[SCR_W-1:8]};
`else
    assign io_rxd            = '0;
    assign io_rx_dv          = 1'b0;
    assign io_rx_er          = 1'b0;
    assign io_rxerror_status = 1'b0;
    assign io_col            = 1'b0;

    assign w_unused = ^{io_n[31:1], io_n0[31:1], w_scr[SCR_W-1:8],
                        io_rx_symb_vector_valid, io_rx_symb_vector_bits_0,
                        io_rx_symb_vector_bits_1, io_rx_symb_vector_bits_2,
                        io_rx_symb_vector_bits_3, io_decoded_rx_symb_vector,
                        w_tx_active_nx};
`endif

endmodule

// File: tb/tb_encoder_txrx_sm.sv
// tb_encoder_txrx_sm: directed self-checking bench for encoder_txrx_sm.
// Expected symbol vectors are hand-computed from the scrambler sequence
// (seed 1 shifting left one bit per strobe for the first dozen strobes).
module tb_encoder_txrx_sm;

  localparam logic [2:0] M2 = 3'b110;
  localparam logic [2:0] M1 = 3'b111;
  localparam logic [2:0] Z0 = 3'b000;
  localparam logic [2:0] P2 = 3'b010;

  // {lane3, lane2, lane1, lane0}
  localparam logic [11:0] V_SSD1 = {P2, P2, P2, P2};
  localparam logic [11:0] V_SSD2 = {M2, M2, P2, P2};
  localparam logic [11:0] V_ESD1 = {M2, P2, M2, P2};
  localparam logic [11:0] V_ESD2 = {P2, M2, P2, M2};
  localparam logic [11:0] V_TERR = {P2, M2, M2, M2};

  logic              clock = 1'b0;
  logic              reset;
  logic              tx_enable, tx_mode, tx_error;
  logic [7:0]        txd;
  logic              symb_timer_done;
  logic [31:0]       n, n0;
  logic              loc_rcvr_status;
  logic              rx_valid;
  logic signed [2:0] rx_b0, rx_b1, rx_b2, rx_b3;
  logic [7:0]        rx_decoded;
  logic              pcs_reset;
  logic              tx_ready;
  logic              tx_valid;
  logic signed [2:0] tx_b0, tx_b1, tx_b2, tx_b3;
  logic [7:0]        rxd;
  logic              rx_dv, rx_er, rxerror_status, col, rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  encoder_txrx_sm dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_tx_enable              (tx_enable),
    .io_tx_mode                (tx_mode),
    .io_tx_error               (tx_error),
    .io_txd                    (txd),
    .io_symb_timer_done        (symb_timer_done),
    .io_n                      (n),
    .io_n0                     (n0),
    .io_loc_rcvr_status        (loc_rcvr_status),
    .io_rx_symb_vector_valid   (rx_valid),
    .io_rx_symb_vector_bits_0  (rx_b0),
    .io_rx_symb_vector_bits_1  (rx_b1),
    .io_rx_symb_vector_bits_2  (rx_b2),
    .io_rx_symb_vector_bits_3  (rx_b3),
    .io_decoded_rx_symb_vector (rx_decoded),
    .io_pcs_reset              (pcs_reset),
    .io_tx_symb_vector_ready   (tx_ready),
    .io_tx_symb_vector_valid   (tx_valid),
    .io_tx_symb_vector_bits_0  (tx_b0),
    .io_tx_symb_vector_bits_1  (tx_b1),
    .io_tx_symb_vector_bits_2  (tx_b2),
    .io_tx_symb_vector_bits_3  (tx_b3),
    .io_rxd                    (rxd),
    .io_rx_dv                  (rx_dv),
    .io_rx_er                  (rx_er),
    .io_rxerror_status         (rxerror_status),
    .io_col                    (col),
    .io_rx_symb_vector_ready   (rx_ready)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] tx_vec();
    return {tx_b3, tx_b2, tx_b1, tx_b0};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_rx(input logic v, input logic [11:0] vec, input logic [7:0] dec);
    rx_valid   = v;
    rx_b0      = vec[2:0];
    rx_b1      = vec[5:3];
    rx_b2      = vec[8:6];
    rx_b3      = vec[11:9];
    rx_decoded = dec;
  endtask

  task automatic check_sym(input string tag, input logic [11:0] exp);
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_sym"}, 32'(tx_vec()), 32'(exp));
  endtask

  initial begin
    reset = 1'b1; pcs_reset = 1'b0;
    tx_enable = 1'b0; tx_mode = 1'b1; tx_error = 1'b0; txd = 8'h00;
    symb_timer_done = 1'b0; tx_ready = 1'b1;
    n = 32'd0; n0 = 32'd0; loc_rcvr_status = 1'b1;
    drive_rx(1'b0, 12'h000, 8'h00);

    // reset state
    step(); step();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_sym", 32'(tx_vec()), 32'd0);
    check("rst_rxd", 32'(rxd), 32'd0);
    check("rst_rx_dv", 32'(rx_dv), 32'd0);
    check("rst_rx_er", 32'(rx_er), 32'd0);
    check("rst_rxerr", 32'(rxerror_status), 32'd0);
    check("rst_col", 32'(col), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_scr", 32'(dut.u_scrambler.r_scr), 32'd1);

    // frame with txd=0xAA, strobe every cycle
    reset = 1'b0; tx_enable = 1'b1; txd = 8'hAA; symb_timer_done = 1'b1;
    step(); check_sym("ssd1", V_SSD1);                       // scr 1 -> 2
    check("col_tx_only", 32'(col), 32'd0);
    step(); check_sym("ssd2", V_SSD2);                       // scr 2 -> 4
    step(); check_sym("data_ae", {M1, M1, P2, M1});          // 0xAA^0x04=0xAE
    step(); check_sym("data_a2", {M1, M1, Z0, M1});          // 0xAA^0x08=0xA2
    tx_error = 1'b1;
    step(); check_sym("data_err", V_TERR);                   // scr 0x10 -> 0x20
    tx_error = 1'b0; tx_mode = 1'b0;
    step(); check_sym("send_z", 12'h000);                    // scr 0x20 -> 0x40
    tx_mode = 1'b1; symb_timer_done = 1'b0;
    step(); check("no_strobe_valid", 32'(tx_valid), 32'd0);
    symb_timer_done = 1'b1; tx_enable = 1'b0;
    step(); check_sym("esd1", V_ESD1);                       // scr 0x40 -> 0x80
    step(); check_sym("esd2", V_ESD2);                       // scr 0x80 -> 0x100
    step(); check_sym("idle_scr100", {M2, M2, M2, M2});      // scr 0x100 -> 0x200

    // synchronous PCS reset
    pcs_reset = 1'b1;
    step();
    check("pcs_rst_valid", 32'(tx_valid), 32'd0);
    check("pcs_rst_sym", 32'(tx_vec()), 32'd0);
    check("pcs_rst_scr", 32'(dut.u_scrambler.r_scr), 32'd1);
    pcs_reset = 1'b0;

    // idle symbols and index parity
    step(); check_sym("idle_scr1", {M2, M2, M2, P2});        // scr 1 -> 2
    n = 32'd5; n0 = 32'd2;
    step(); check_sym("idle_odd", {P2, M2, P2, M2});         // scr 2 -> 4
    n = 32'd4; loc_rcvr_status = 1'b0; tx_enable = 1'b1;
    step(); check_sym("idle_blocked", {M2, P2, M2, M2});     // scr 4 -> 8
    loc_rcvr_status = 1'b1; txd = 8'h00;
    step(); check_sym("ssd1_b", V_SSD1);                     // scr 8 -> 0x10
    tx_enable = 1'b0;
    step(); check_sym("ssd2_drop", V_SSD2);                  // scr 0x10 -> 0x20
    step(); check_sym("data_20", {Z0, M1, Z0, Z0});          // 0x00^0x20=0x20
    step(); check_sym("esd1_b", V_ESD1);
    step(); check_sym("esd2_b", V_ESD2);

    // asynchronous reset mid-frame
    tx_enable = 1'b1; txd = 8'h3C;
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 32'd0);
    check("async_rst_sym", 32'(tx_vec()), 32'd0);
    tx_enable = 1'b0;
    step();
    reset = 1'b0;
    step(); check_sym("after_abort_idle", {M2, M2, M2, P2}); // scr 1, no ESD

`ifdef ENCODER_TXRX_SM_RX_EN
    // receive frame
    drive_rx(1'b1, V_SSD1, 8'h00);
    step(); check("rx_ssd1_dv", 32'(rx_dv), 32'd0);
    drive_rx(1'b1, V_SSD2, 8'h00);
    step(); check("rx_ssd2_dv", 32'(rx_dv), 32'd0);
    check("rx_ssd2_er", 32'(rx_er), 32'd0);
    drive_rx(1'b1, 12'h000, 8'h55);
    step(); check("rx_d55_dv", 32'(rx_dv), 32'd1);
    check("rx_d55_rxd", 32'(rxd), 32'h55);
    drive_rx(1'b1, {M1, Z0, P2, M1}, 8'h66);
    step(); check("rx_d66_rxd", 32'(rxd), 32'h66);
    drive_rx(1'b1, V_ESD1, 8'h00);
    step(); check("rx_esd1_dv", 32'(rx_dv), 32'd0);

    // bad second delimiter
    drive_rx(1'b1, V_SSD1, 8'h00);
    step();
    drive_rx(1'b1, 12'h000, 8'h00);
    step(); check("rx_bad_er", 32'(rx_er), 32'd1);
    check("rx_bad_status", 32'(rxerror_status), 32'd1);
    drive_rx(1'b0, 12'h000, 8'h00);
    step(); check("rx_er_pulse", 32'(rx_er), 32'd0);
    check("rx_status_sticky", 32'(rxerror_status), 32'd1);
    pcs_reset = 1'b1;
    step(); check("rx_status_clear", 32'(rxerror_status), 32'd0);
    pcs_reset = 1'b0;

    // collision: TX leaves IDLE while RX is in a frame
    tx_enable = 1'b1;
    drive_rx(1'b1, V_SSD1, 8'h00);
    step(); check("col_both", 32'(col), 32'd1);
    drive_rx(1'b0, V_SSD1, 8'h00);
    step(); check("col_hold", 32'(col), 32'd1);
    tx_enable = 1'b0;
`else
    // RX disabled: outputs stay tied off under RX stimulus
    tx_enable = 1'b1;
    drive_rx(1'b1, V_SSD1, 8'h00);
    step(); check("norx_col", 32'(col), 32'd0);
    drive_rx(1'b1, V_SSD2, 8'h00);
    step();
    drive_rx(1'b1, 12'h000, 8'h55);
    step(); check("norx_dv", 32'(rx_dv), 32'd0);
    check("norx_rxd", 32'(rxd), 32'd0);
    drive_rx(1'b1, V_SSD1, 8'h00);
    step();
    drive_rx(1'b1, 12'h000, 8'h00);
    step(); check("norx_er", 32'(rx_er), 32'd0);
    check("norx_status", 32'(rxerror_status), 32'd0);
    check("norx_ready", 32'(rx_ready), 32'd1);
    tx_enable = 1'b0;
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
